// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings, frame constants and default
// parameter values used by uart_fifo and uart_tx_fifo.
package uart_pkg;

   localparam int unsigned CLKS_PER_BIT_DEF = 16;
   localparam int unsigned FIFO_DEPTH_DEF   = 16;
   localparam int unsigned RX_MEM_DEPTH_DEF = 1024;

   localparam logic        START_BIT = 1'b0;
   localparam logic        STOP_BIT  = 1'b1;
   localparam int unsigned DATA_BITS = 8;

   typedef enum logic [1:0] {
      TX_IDLE,
      TX_START,
      TX_DATA,
      TX_STOP
   } tx_state_e;

   typedef enum logic [1:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
      RX_STOP
   } rx_state_e;

endpackage

// File: rtl/uart_tx_fifo.sv
// Transmit FIFO: count-based full/empty with wrapping read/write pointers.
// Storage is not reset; the head entry is presented combinationally.
module uart_tx_fifo
   import uart_pkg::*;
#(
   parameter int unsigned DEPTH = FIFO_DEPTH_DEF,
   parameter int unsigned DW    = 8
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   input  logic          push_i,
   input  logic [DW-1:0] push_data_i,
   input  logic          pop_i,
   output logic [DW-1:0] head_o,
   output logic          full_o,
   output logic          empty_o
);

   localparam int unsigned    AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [AW:0]    FULL_CNT = (AW+1)'(DEPTH);

   logic [DW-1:0] mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   count_q, count_d;
   logic          do_push, do_pop;

   assign full_o  = (count_q == FULL_CNT);
   assign empty_o = (count_q == '0);
   assign head_o  = mem_q[rd_ptr_q];

   // Push is gated on the registered full flag, so a simultaneous pop never
   // makes room for a push into a full FIFO.
   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (do_push && !do_pop)      count_d = count_q + 1'b1;
      else if (do_pop && !do_push) count_d = count_q - 1'b1;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wr_ptr_q] <= push_data_i;
   end

endmodule

// File: rtl/uart_fifo.sv
// UART with buffered transmitter and memory-backed receiver.
// Define UART_LOOPBACK_EN to feed the receiver from tx_out and ignore rx_in.
module uart_fifo
   import uart_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEF,
   parameter int unsigned FIFO_DEPTH   = FIFO_DEPTH_DEF,
   parameter int unsigned RX_MEM_DEPTH = RX_MEM_DEPTH_DEF
) (
   input  logic                            clk_t_in,
   input  logic                            rst_n,
   input  logic [7:0]                      pc_in_t,
   input  logic                            wr_en,
   output logic                            tx_out,
   input  logic                            rx_in,
   output logic                            done,
   output logic [7:0]                      rx_data,
   output logic                            fifo_tx_full,
   output logic                            fifo_tx_empty,
   input  logic [$clog2(RX_MEM_DEPTH)-1:0] mem_addr,
   output logic [7:0]                      mem_rdata
);

   localparam int unsigned      CNT_W    = $clog2(CLKS_PER_BIT);
   localparam int unsigned      MEM_AW   = $clog2(RX_MEM_DEPTH);
   localparam logic [CNT_W-1:0] BIT_END  = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] HALF_END = CNT_W'(CLKS_PER_BIT/2 - 1);
   localparam logic [2:0]       LAST_BIT = 3'(DATA_BITS - 1);

   logic       fifo_pop;
   logic [7:0] fifo_head;

   uart_tx_fifo #(
      .DEPTH (FIFO_DEPTH),
      .DW    (8)
   ) u_tx_fifo (
      .clk_i       (clk_t_in),
      .rst_ni      (rst_n),
      .push_i      (wr_en),
      .push_data_i (pc_in_t),
      .pop_i       (fifo_pop),
      .head_o      (fifo_head),
      .full_o      (fifo_tx_full),
      .empty_o     (fifo_tx_empty)
   );

   tx_state_e        tx_state_q, tx_state_d;
   logic [CNT_W-1:0] tx_cnt_q, tx_cnt_d;
   logic [2:0]       tx_bit_q, tx_bit_d;
   logic [7:0]       tx_shift_q, tx_shift_d;
   logic             tx_q, tx_d;
   logic             tx_bit_end;

   assign tx_bit_end = (tx_cnt_q == BIT_END);
   assign tx_out     = tx_q;

   always_comb begin
      tx_state_d = tx_state_q;
      tx_cnt_d   = tx_cnt_q;
      tx_bit_d   = tx_bit_q;
      tx_shift_d = tx_shift_q;
      tx_d       = tx_q;
      fifo_pop   = 1'b0;
      if (tx_state_q != TX_IDLE) tx_cnt_d = tx_bit_end ? '0 : tx_cnt_q + 1'b1;
      unique case (tx_state_q)
         TX_IDLE: begin
            if (!fifo_tx_empty) begin
               fifo_pop   = 1'b1;
               tx_shift_d = fifo_head;
               tx_cnt_d   = '0;
               tx_d       = START_BIT;
               tx_state_d = TX_START;
            end
         end
         TX_START: begin
            if (tx_bit_end) begin
               tx_bit_d   = '0;
               tx_d       = tx_shift_q[0];
               tx_state_d = TX_DATA;
            end
         end
         TX_DATA: begin
            if (tx_bit_end) begin
               if (tx_bit_q == LAST_BIT) begin
                  tx_d       = STOP_BIT;
                  tx_state_d = TX_STOP;
               end else begin
                  tx_bit_d   = tx_bit_q + 3'd1;
                  tx_shift_d = tx_shift_q >> 1;
                  tx_d       = tx_shift_q[1];
               end
            end
         end
         TX_STOP: begin
            // Chain straight into the next start bit for back-to-back frames.
            if (tx_bit_end) begin
               if (!fifo_tx_empty) begin
                  fifo_pop   = 1'b1;
                  tx_shift_d = fifo_head;
                  tx_d       = START_BIT;
                  tx_state_d = TX_START;
               end else begin
                  tx_state_d = TX_IDLE;
               end
            end
         end
         default: tx_state_d = TX_IDLE;
      endcase
   end

   always_ff @(posedge clk_t_in or negedge rst_n) begin
      if (!rst_n) begin
         tx_state_q <= TX_IDLE;
         tx_cnt_q   <= '0;
         tx_bit_q   <= '0;
         tx_shift_q <= '0;
         tx_q       <= STOP_BIT;
      end else begin
         tx_state_q <= tx_state_d;
         tx_cnt_q   <= tx_cnt_d;
         tx_bit_q   <= tx_bit_d;
         tx_shift_q <= tx_shift_d;
         tx_q       <= tx_d;
      end
   end

   logic rx_src;
`ifdef UART_LOOPBACK_EN
   logic unused_rx_in;
   assign unused_rx_in = rx_in;
   assign rx_src       = tx_q;
`else
   assign rx_src       = rx_in;
`endif

   rx_state_e         rx_state_q, rx_state_d;
   logic [CNT_W-1:0]  rx_cnt_q, rx_cnt_d;
   logic [2:0]        rx_bit_q, rx_bit_d;
   logic [7:0]        rx_shift_q, rx_shift_d;
   logic              rx_err_q, rx_err_d;
   logic [7:0]        rx_data_q, rx_data_d;
   logic              done_q, done_d;
   logic [MEM_AW-1:0] wr_ptr_q, wr_ptr_d;
   logic              sync1_q, sync2_q;
   logic              mem_we;
   logic              rx_bit_end;
   logic [7:0]        rx_mem_q [RX_MEM_DEPTH];

   assign rx_bit_end = (rx_cnt_q == BIT_END);
   assign done       = done_q;
   assign rx_data    = rx_data_q;
   assign mem_rdata  = rx_mem_q[mem_addr];

   always_comb begin
      rx_state_d = rx_state_q;
      rx_cnt_d   = rx_cnt_q;
      rx_bit_d   = rx_bit_q;
      rx_shift_d = rx_shift_q;
      rx_err_d   = rx_err_q;
      rx_data_d  = rx_data_q;
      wr_ptr_d   = wr_ptr_q;
      done_d     = 1'b0;
      mem_we     = 1'b0;
      if (rx_state_q != RX_IDLE) rx_cnt_d = rx_cnt_q + 1'b1;
      unique case (rx_state_q)
         RX_IDLE: begin
            if (sync2_q == START_BIT) begin
               rx_cnt_d   = '0;
               rx_state_d = RX_START;
            end
         end
         RX_START: begin
            if (rx_cnt_q == HALF_END) begin
               rx_cnt_d   = '0;
               rx_bit_d   = '0;
               rx_state_d = (sync2_q == START_BIT) ? RX_DATA : RX_IDLE;
            end
         end
         RX_DATA: begin
            if (rx_bit_end) begin
               rx_cnt_d   = '0;
               rx_shift_d = {sync2_q, rx_shift_q[7:1]};
               if (rx_bit_q == LAST_BIT) rx_state_d = RX_STOP;
               else                      rx_bit_d   = rx_bit_q + 3'd1;
            end
         end
         RX_STOP: begin
            // After a framing error, hold here until the line returns high.
            if (rx_err_q) begin
               if (sync2_q == STOP_BIT) begin
                  rx_err_d   = 1'b0;
                  rx_cnt_d   = '0;
                  rx_state_d = RX_IDLE;
               end
            end else if (rx_bit_end) begin
               rx_cnt_d = '0;
               if (sync2_q == STOP_BIT) begin
                  mem_we     = 1'b1;
                  wr_ptr_d   = wr_ptr_q + 1'b1;
                  rx_data_d  = rx_shift_q;
                  done_d     = 1'b1;
                  rx_state_d = RX_IDLE;
               end else begin
                  rx_err_d = 1'b1;
               end
            end
         end
         default: rx_state_d = RX_IDLE;
      endcase
   end

   always_ff @(posedge clk_t_in or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q    <= 1'b1;
         sync2_q    <= 1'b1;
         rx_state_q <= RX_IDLE;
         rx_cnt_q   <= '0;
         rx_bit_q   <= '0;
         rx_shift_q <= '0;
         rx_err_q   <= 1'b0;
         rx_data_q  <= '0;
         done_q     <= 1'b0;
         wr_ptr_q   <= '0;
      end else begin
         sync1_q    <= rx_src;
         sync2_q    <= sync1_q;
         rx_state_q <= rx_state_d;
         rx_cnt_q   <= rx_cnt_d;
         rx_bit_q   <= rx_bit_d;
         rx_shift_q <= rx_shift_d;
         rx_err_q   <= rx_err_d;
         rx_data_q  <= rx_data_d;
         done_q     <= done_d;
         wr_ptr_q   <= wr_ptr_d;
      end
   end

   always_ff @(posedge clk_t_in) begin
      if (mem_we) rx_mem_q[wr_ptr_q] <= rx_shift_q;
   end

endmodule

// File: tb/tb_uart_fifo.sv
// Self-checking bench for uart_fifo: queue/frame-timer reference model for the
// TX path, loopback (internal or bench-wired) for RX, bit-banged error frames.
module tb_uart_fifo;

   localparam int unsigned CPB    = 16;
   localparam int unsigned CPB2   = 4;
   localparam int unsigned FDEPTH = 16;
   localparam int unsigned MDEPTH = 1024;
   localparam int unsigned FRAME  = 10 * CPB;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic [7:0] pc_in_t = '0;
   logic       wr_en = 1'b0;
   logic       tx_out, rx_in, done;
   logic [7:0] rx_data, mem_rdata;
   logic       fifo_tx_full, fifo_tx_empty;
   logic [9:0] mem_addr = '0;
   logic       lb_en = 1'b1;
   logic       rx_drv = 1'b1;

   logic [7:0] pc_in2 = '0;
   logic       wr2 = 1'b0;
   logic       tx_out2, done2, full2, empty2;
   logic [7:0] rx_data2, mem_rdata2;
   logic [9:0] mem_addr2 = '0;

   assign rx_in = lb_en ? tx_out : rx_drv;

   always #5 clk = ~clk;

   uart_fifo #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(FDEPTH), .RX_MEM_DEPTH(MDEPTH)) dut (
      .clk_t_in(clk), .rst_n(rst_n), .pc_in_t(pc_in_t), .wr_en(wr_en),
      .tx_out(tx_out), .rx_in(rx_in), .done(done), .rx_data(rx_data),
      .fifo_tx_full(fifo_tx_full), .fifo_tx_empty(fifo_tx_empty),
      .mem_addr(mem_addr), .mem_rdata(mem_rdata));

   uart_fifo #(.CLKS_PER_BIT(CPB2), .FIFO_DEPTH(FDEPTH), .RX_MEM_DEPTH(MDEPTH)) dut_wrap (
      .clk_t_in(clk), .rst_n(rst_n), .pc_in_t(pc_in2), .wr_en(wr2),
      .tx_out(tx_out2), .rx_in(tx_out2), .done(done2), .rx_data(rx_data2),
      .fifo_tx_full(full2), .fifo_tx_empty(empty2),
      .mem_addr(mem_addr2), .mem_rdata(mem_rdata2));

   int          vectors = 0;
   int          errors  = 0;
   int unsigned cyc     = 0;

   // Reference model: pending bytes, bytes put on the wire, cycles left in frame.
   logic [7:0]  m_q[$];
   logic [7:0]  sent_q[$];
   int unsigned m_rem = 0;

   logic [7:0]  rx_got[$];
   int unsigned rx_cyc[$];
   int unsigned rx_addr[$];
   int unsigned rx_ptr  = 0;
   int unsigned rx2_cnt = 0;
   logic [7:0]  b2 [MDEPTH+1];

   task automatic clear_model();
      m_q.delete(); sent_q.delete(); m_rem = 0;
      rx_got.delete(); rx_cyc.delete(); rx_addr.delete();
      rx_ptr = 0; rx2_cnt = 0;
   endtask

   task automatic step(input logic we, input logic [7:0] d);
      int unsigned sz;
      sz = m_q.size();
      wr_en = we; pc_in_t = d;
      if (rst_n) begin
         if (m_rem <= 1 && sz > 0) begin
            sent_q.push_back(m_q.pop_front());
            m_rem = FRAME;
         end else if (m_rem > 0) begin
            m_rem--;
         end
         if (we && sz < FDEPTH) m_q.push_back(d);
      end
      @(posedge clk); #1;
      cyc++;
      if (done) begin
         rx_got.push_back(rx_data); rx_cyc.push_back(cyc); rx_addr.push_back(rx_ptr);
         rx_ptr = (rx_ptr + 1) % MDEPTH;
      end
      if (done2) rx2_cnt++;
   endtask

   task automatic apply_reset();
      @(negedge clk);
      rst_n = 1'b0; wr_en = 1'b0; wr2 = 1'b0;
      clear_model();
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   task automatic wait_rx(input int unsigned n, input int unsigned budget);
      int unsigned k = 0;
      while (rx_got.size() < n && k < budget) begin
         step(1'b0, 8'h00); k++;
      end
   endtask

   task automatic test_reset();
      #2 rst_n = 1'b0;
      #1;
      vectors++; if (tx_out !== 1'b1) begin errors++; $display("FAIL reset_async_tx_out: got %b want 1", tx_out); end
      repeat (2) @(posedge clk); #1;
      vectors++; if (tx_out !== 1'b1) begin errors++; $display("FAIL reset_tx_out: got %b want 1", tx_out); end
      vectors++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
      vectors++; if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_rx_data: got %h want 00", rx_data); end
      vectors++; if (fifo_tx_empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b want 1", fifo_tx_empty); end
      vectors++; if (fifo_tx_full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b want 0", fifo_tx_full); end
      vectors++; if (tx_out2 !== 1'b1 || empty2 !== 1'b1) begin errors++; $display("FAIL reset_wrap_inst: tx %b empty %b want 1 1", tx_out2, empty2); end
      clear_model();
      #1 rst_n = 1'b1;
   endtask

   task automatic test_single();
      logic [7:0]  b;
      logic [9:0]  frame;
      int unsigned push_cyc;
      b = 8'h77;
      frame = {1'b1, b, 1'b0};
      apply_reset();
      step(1'b1, b); push_cyc = cyc;
      step(1'b0, 8'h00);
      repeat (8) step(1'b0, 8'h00);
      for (int k = 0; k < 10; k++) begin
         vectors++;
         if (tx_out !== frame[k]) begin errors++; $display("FAIL single_frame_bit%0d: got %b want %b", k, tx_out, frame[k]); end
         if (k < 9) repeat (CPB) step(1'b0, 8'h00);
      end
      wait_rx(1, 40);
      vectors++;
      if (rx_got.size() < 1 || rx_cyc[0] - push_cyc > 164) begin
         errors++; $display("FAIL single_done_latency: %0d pulses seen, limit 164 cycles", rx_got.size());
      end
      repeat (60) step(1'b0, 8'h00);
      vectors++; if (rx_got.size() != 1) begin errors++; $display("FAIL single_done_count: got %0d want 1", rx_got.size()); end
      vectors++; if (rx_data !== b) begin errors++; $display("FAIL single_rx_data: got %h want %h", rx_data, b); end
      mem_addr = 10'd0; #1;
      vectors++; if (mem_rdata !== b) begin errors++; $display("FAIL single_mem0: got %h want %h", mem_rdata, b); end
      vectors++; if (fifo_tx_empty !== 1'b1 || tx_out !== 1'b1) begin errors++; $display("FAIL single_idle: empty %b tx %b want 1 1", fifo_tx_empty, tx_out); end
   endtask

   task automatic test_burst();
      apply_reset();
      for (int i = 0; i < 16; i++) begin
         step(1'b1, 8'(i));
         vectors++; if (fifo_tx_full !== (m_q.size() == FDEPTH)) begin errors++; $display("FAIL burst_full[%0d]: got %b want %b", i, fifo_tx_full, m_q.size() == FDEPTH); end
         vectors++; if (fifo_tx_empty !== (m_q.size() == 0)) begin errors++; $display("FAIL burst_empty[%0d]: got %b want %b", i, fifo_tx_empty, m_q.size() == 0); end
      end
      wait_rx(16, 16 * FRAME + 200);
      vectors++; if (rx_got.size() != 16) begin errors++; $display("FAIL burst_count: got %0d want 16", rx_got.size()); end
      for (int i = 0; i < rx_got.size(); i++) begin
         vectors++; if (rx_got[i] !== 8'(i)) begin errors++; $display("FAIL burst_rx[%0d]: got %h want %h", i, rx_got[i], 8'(i)); end
         mem_addr = 10'(i); #1;
         vectors++; if (mem_rdata !== 8'(i)) begin errors++; $display("FAIL burst_mem[%0d]: got %h want %h", i, mem_rdata, 8'(i)); end
         if (i > 0) begin
            vectors++;
            if (rx_cyc[i] - rx_cyc[i-1] != FRAME) begin errors++; $display("FAIL burst_spacing[%0d]: got %0d want %0d", i, rx_cyc[i] - rx_cyc[i-1], FRAME); end
         end
      end
      vectors++; if (fifo_tx_empty !== 1'b1) begin errors++; $display("FAIL burst_end_empty: got %b want 1", fifo_tx_empty); end
   endtask

   task automatic test_overflow();
      apply_reset();
      for (int i = 0; i < 18; i++) step(1'b1, 8'($urandom));
      vectors++; if (fifo_tx_full !== (m_q.size() == FDEPTH)) begin errors++; $display("FAIL ovf_full: got %b want %b", fifo_tx_full, m_q.size() == FDEPTH); end
      wait_rx(sent_q.size() + m_q.size(), 20 * FRAME);
      repeat (2 * FRAME) step(1'b0, 8'h00);
      vectors++; if (rx_got.size() != sent_q.size()) begin errors++; $display("FAIL ovf_count: got %0d want %0d", rx_got.size(), sent_q.size()); end
      for (int i = 0; i < rx_got.size() && i < sent_q.size(); i++) begin
         vectors++; if (rx_got[i] !== sent_q[i]) begin errors++; $display("FAIL ovf_rx[%0d]: got %h want %h", i, rx_got[i], sent_q[i]); end
      end
      vectors++; if (fifo_tx_empty !== 1'b1) begin errors++; $display("FAIL ovf_end_empty: got %b want 1", fifo_tx_empty); end
   endtask

   task automatic test_reset_mid();
      rx_got.delete(); rx_cyc.delete(); rx_addr.delete();
      step(1'b1, 8'($urandom));
      repeat (1 + CPB + 40) step(1'b0, 8'h00);
      #3 rst_n = 1'b0;
      #1;
      vectors++; if (tx_out !== 1'b1) begin errors++; $display("FAIL mid_reset_tx_out: got %b want 1", tx_out); end
      vectors++; if (fifo_tx_empty !== 1'b1 || fifo_tx_full !== 1'b0) begin errors++; $display("FAIL mid_reset_flags: empty %b full %b want 1 0", fifo_tx_empty, fifo_tx_full); end
      vectors++; if (done !== 1'b0 || rx_data !== 8'h00) begin errors++; $display("FAIL mid_reset_rx: done %b data %h want 0 00", done, rx_data); end
      clear_model();
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst_n = 1'b1;
      step(1'b1, 8'hA5);
      wait_rx(1, FRAME + 40);
      repeat (FRAME) step(1'b0, 8'h00);
      vectors++; if (rx_got.size() != 1) begin errors++; $display("FAIL mid_after_count: got %0d want 1", rx_got.size()); end
      vectors++; if (rx_data !== 8'hA5) begin errors++; $display("FAIL mid_after_rx_data: got %h want a5", rx_data); end
      mem_addr = 10'd0; #1;
      vectors++; if (mem_rdata !== 8'hA5) begin errors++; $display("FAIL mid_after_mem0: got %h want a5", mem_rdata); end
   endtask

`ifndef UART_LOOPBACK_EN
   task automatic test_rx_errors();
      logic [7:0] b, c;
      logic [9:0] bits;
      apply_reset();
      lb_en = 1'b0; rx_drv = 1'b1;
      repeat (4) step(1'b0, 8'h00);
      rx_drv = 1'b0; repeat (4) step(1'b0, 8'h00);
      rx_drv = 1'b1; repeat (3 * CPB) step(1'b0, 8'h00);
      vectors++; if (rx_got.size() != 0) begin errors++; $display("FAIL rx_glitch: got %0d done pulses want 0", rx_got.size()); end
      b = 8'($urandom);
      bits = {1'b0, b, 1'b0};
      for (int k = 0; k < 10; k++) begin rx_drv = bits[k]; repeat (CPB) step(1'b0, 8'h00); end
      repeat (2 * CPB) step(1'b0, 8'h00);
      rx_drv = 1'b1; repeat (2 * CPB) step(1'b0, 8'h00);
      vectors++; if (rx_got.size() != 0) begin errors++; $display("FAIL rx_framing: got %0d done pulses want 0", rx_got.size()); end
      c = 8'($urandom);
      bits = {1'b1, c, 1'b0};
      for (int k = 0; k < 10; k++) begin rx_drv = bits[k]; repeat (CPB) step(1'b0, 8'h00); end
      rx_drv = 1'b1; repeat (2 * CPB) step(1'b0, 8'h00);
      vectors++; if (rx_got.size() != 1 || rx_data !== c) begin errors++; $display("FAIL rx_good_after_err: %0d pulses data %h want 1 %h", rx_got.size(), rx_data, c); end
      mem_addr = 10'd0; #1;
      vectors++; if (mem_rdata !== c) begin errors++; $display("FAIL rx_wr_ptr_kept: mem0 %h want %h", mem_rdata, c); end
      lb_en = 1'b1;
   endtask
`endif

   task automatic test_wrap();
      int unsigned pushed = 0;
      int unsigned k = 0;
      apply_reset();
      while ((pushed < MDEPTH + 1 || rx2_cnt < MDEPTH + 1) && k < 60000) begin
         if (pushed < MDEPTH + 1 && !full2) begin
            wr2 = 1'b1; pc_in2 = 8'($urandom); b2[pushed] = pc_in2; pushed++;
         end else begin
            wr2 = 1'b0;
         end
         step(1'b0, 8'h00); k++;
      end
      wr2 = 1'b0;
      vectors++; if (rx2_cnt != MDEPTH + 1) begin errors++; $display("FAIL wrap_count: got %0d want %0d", rx2_cnt, MDEPTH + 1); end
      vectors++; if (rx_data2 !== b2[MDEPTH]) begin errors++; $display("FAIL wrap_rx_data: got %h want %h", rx_data2, b2[MDEPTH]); end
      mem_addr2 = 10'd0; #1;
      vectors++; if (mem_rdata2 !== b2[MDEPTH]) begin errors++; $display("FAIL wrap_mem0: got %h want %h", mem_rdata2, b2[MDEPTH]); end
      mem_addr2 = 10'd1; #1;
      vectors++; if (mem_rdata2 !== b2[1]) begin errors++; $display("FAIL wrap_mem1: got %h want %h", mem_rdata2, b2[1]); end
      mem_addr2 = 10'd1023; #1;
      vectors++; if (mem_rdata2 !== b2[MDEPTH-1]) begin errors++; $display("FAIL wrap_mem1023: got %h want %h", mem_rdata2, b2[MDEPTH-1]); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_burst();
      test_overflow();
      test_reset_mid();
`ifndef UART_LOOPBACK_EN
      test_rx_errors();
`endif
      test_wrap();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
